// File: rtl/video_mode_ctrl.sv
// rtl/video_mode_ctrl.sv - frame-synchronous display-source sequencer for the video output mux
// Optional automatic cycling is built only when VIDEO_MODE_AUTO_CYCLE_EN is defined.
module video_mode_ctrl #(
    parameter int NUM_MODES     = 4,
    parameter int SETTLE_FRAMES = 2,
    parameter int AUTO_FRAMES   = 600
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       next_mode_in,
    input  logic [1:0] direct_mode_in,
    input  logic       direct_val_in,
    input  logic       new_frame_in,
    input  logic       camera_ready_in,
    input  logic       auto_in,
    output logic [1:0] bg_out,
    output logic       blank_out,
    output logic       pending_out,
    output logic       mode_changed_out
);

    typedef enum logic [1:0] {
        STEADY  = 2'd0,
        PENDING = 2'd1,
        SETTLE  = 2'd2
    } state_t;

    localparam logic [2:0] MODE_LIMIT  = 3'(NUM_MODES);
    localparam logic [1:0] LAST_MODE   = 2'(NUM_MODES - 1);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_FRAMES);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] target;
    logic [1:0] target_nxt;
    logic [1:0] bg_nxt;
    logic [3:0] settle_cnt;
    logic [3:0] settle_nxt;
    logic       mc_nxt;
    logic       latched;
    logic       latched_nxt;

    logic       auto_req;
    logic       req_valid;
    logic [1:0] req_mode;
    logic [1:0] eff_mode;

`ifdef VIDEO_MODE_AUTO_CYCLE_EN
    localparam int AW = $clog2(AUTO_FRAMES + 1);
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_FRAMES - 1);

    logic [AW-1:0] auto_cnt;
    logic [AW-1:0] auto_nxt;

    // Count steady frames while auto mode is on; any manual request restarts the count
    always_comb begin
        auto_req = 1'b0;
        auto_nxt = auto_cnt;
        if (!auto_in || next_mode_in || direct_val_in) begin
            auto_nxt = '0;
        end else if (state == STEADY && new_frame_in) begin
            if (auto_cnt >= AUTO_LAST) begin
                auto_req = 1'b1;
                auto_nxt = '0;
            end else begin
                auto_nxt = auto_cnt + 1'b1;
            end
        end
    end

    // Auto frame counter register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_nxt;
        end
    end
`else
    localparam int unused_auto_frames = AUTO_FRAMES;
    logic unused_auto_in;
    assign unused_auto_in = auto_in;
    assign auto_req       = 1'b0;
`endif

    // Request capture: direct select beats step; steps chain from the latest target
    always_comb begin
        req_valid = 1'b0;
        req_mode  = target;
        if (direct_val_in) begin
            if ({1'b0, direct_mode_in} < MODE_LIMIT) begin
                req_valid = 1'b1;
                req_mode  = direct_mode_in;
            end
        end else if (next_mode_in || auto_req) begin
            req_valid = 1'b1;
            req_mode  = (target == LAST_MODE) ? 2'd0 : target + 2'd1;
        end
    end

    // Next-state logic: switches only at frame boundaries, camera modes wait for ready
    always_comb begin
        state_nxt   = state;
        target_nxt  = target;
        bg_nxt      = bg_out;
        settle_nxt  = settle_cnt;
        mc_nxt      = 1'b0;
        latched_nxt = latched;
        eff_mode    = req_valid ? req_mode : target;
        case (state)
            STEADY: begin
                if (req_valid && req_mode != bg_out) begin
                    target_nxt = req_mode;
                    state_nxt  = PENDING;
                end
            end
            PENDING: begin
                target_nxt = eff_mode;
                if (new_frame_in) begin
                    if (eff_mode != 2'd0 && !camera_ready_in) begin
                        state_nxt = PENDING;
                    end else if (eff_mode == bg_out) begin
                        state_nxt = STEADY;
                    end else begin
                        bg_nxt     = eff_mode;
                        mc_nxt     = 1'b1;
                        settle_nxt = SETTLE_LOAD;
                        state_nxt  = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (req_valid) begin
                    target_nxt  = req_mode;
                    latched_nxt = 1'b1;
                end
                if (new_frame_in) begin
                    if (settle_cnt != 4'd0) begin
                        settle_nxt = settle_cnt - 4'd1;
                    end
                    if (settle_cnt <= 4'd1) begin
                        state_nxt   = (latched || req_valid) ? PENDING : STEADY;
                        latched_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = STEADY;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state            <= STEADY;
            target           <= 2'd0;
            bg_out           <= 2'd0;
            settle_cnt       <= 4'd0;
            mode_changed_out <= 1'b0;
            latched          <= 1'b0;
        end else begin
            state            <= state_nxt;
            target           <= target_nxt;
            bg_out           <= bg_nxt;
            settle_cnt       <= settle_nxt;
            mode_changed_out <= mc_nxt;
            latched          <= latched_nxt;
        end
    end

    // Status decode: blanking follows the settle window, pending covers waiting and latched requests
    always_comb begin
        blank_out   = (state == SETTLE);
        pending_out = (state == PENDING) || (state == SETTLE && latched);
    end

endmodule

// File: tb/tb_video_mode_ctrl.sv
// tb/tb_video_mode_ctrl.sv - directed self-checking bench for video_mode_ctrl
module tb_video_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       next_mode = 1'b0;
    logic [1:0] direct_mode = 2'd0;
    logic       direct_val = 1'b0;
    logic       new_frame = 1'b0;
    logic       camera_ready = 1'b0;
    logic       auto_en = 1'b0;
    logic [1:0] bg;
    logic       blank;
    logic       pending;
    logic       mode_changed;

    int n_checks = 0;
    int n_fails  = 0;

    video_mode_ctrl #(
        .NUM_MODES    (4),
        .SETTLE_FRAMES(2),
        .AUTO_FRAMES  (3)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .next_mode_in    (next_mode),
        .direct_mode_in  (direct_mode),
        .direct_val_in   (direct_val),
        .new_frame_in    (new_frame),
        .camera_ready_in (camera_ready),
        .auto_in         (auto_en),
        .bg_out          (bg),
        .blank_out       (blank),
        .pending_out     (pending),
        .mode_changed_out(mode_changed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] e_bg, input logic e_blank,
                           input logic e_pend, input logic e_mc);
        chk({tag, ".bg"}, {2'b00, bg}, {2'b00, e_bg});
        chk({tag, ".blank"}, {3'b000, blank}, {3'b000, e_blank});
        chk({tag, ".pending"}, {3'b000, pending}, {3'b000, e_pend});
        chk({tag, ".mc"}, {3'b000, mode_changed}, {3'b000, e_mc});
    endtask

    task automatic frame();
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
    endtask

    task automatic step();
        next_mode = 1'b1;
        tick();
        next_mode = 1'b0;
    endtask

    task automatic direct(input logic [1:0] m);
        direct_mode = m;
        direct_val  = 1'b1;
        tick();
        direct_val  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk_all("reset", 2'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        camera_ready = 1'b1;
        tick();

        // single step 0 -> 1, frame arrives 10 cycles after the request
        step();
        chk_all("step_pend", 2'd0, 1'b0, 1'b1, 1'b0);
        repeat (9) tick();
        chk_all("step_wait", 2'd0, 1'b0, 1'b1, 1'b0);
        frame();
        chk_all("step_switch", 2'd1, 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("step_after", 2'd1, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        frame();
        chk_all("settle_f1", 2'd1, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        frame();
        chk_all("settle_f2", 2'd1, 1'b0, 1'b0, 1'b0);

        // three steps chain to mode 3, then a fourth wraps to 0
        do_reset();
        chk_all("rst2", 2'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        step();
        chk_all("chain_pend", 2'd0, 1'b0, 1'b1, 1'b0);
        frame();
        chk_all("chain_switch", 2'd3, 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("chain_after", 2'd3, 1'b1, 1'b0, 1'b0);
        frame();
        frame();
        chk_all("chain_settled", 2'd3, 1'b0, 1'b0, 1'b0);
        step();
        frame();
        chk_all("wrap", 2'd0, 1'b1, 1'b0, 1'b1);
        frame();
        frame();

        // direct select wins over a simultaneous step
        direct_mode = 2'd2;
        direct_val  = 1'b1;
        next_mode   = 1'b1;
        tick();
        direct_val  = 1'b0;
        next_mode   = 1'b0;
        chk_all("prio_pend", 2'd0, 1'b0, 1'b1, 1'b0);
        frame();
        chk_all("prio_switch", 2'd2, 1'b1, 1'b0, 1'b1);
        frame();
        frame();
        direct(2'd2);
        chk_all("same_drop", 2'd2, 1'b0, 1'b0, 1'b0);
        frame();
        chk_all("same_frame", 2'd2, 1'b0, 1'b0, 1'b0);

        // camera not ready blocks a camera mode
        do_reset();
        camera_ready = 1'b0;
        direct(2'd1);
        repeat (5) frame();
        chk_all("cam_block", 2'd0, 1'b0, 1'b1, 1'b0);
        camera_ready = 1'b1;
        frame();
        chk_all("cam_ready", 2'd1, 1'b1, 1'b0, 1'b1);

        // request during settle is held until settle ends
        direct(2'd3);
        chk_all("settle_req", 2'd1, 1'b1, 1'b1, 1'b0);
        frame();
        chk_all("settle_req_f1", 2'd1, 1'b1, 1'b1, 1'b0);
        frame();
        chk_all("settle_req_f2", 2'd1, 1'b0, 1'b1, 1'b0);
        frame();
        chk_all("settle_req_sw", 2'd3, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all("rst_settle", 2'd0, 1'b0, 1'b0, 1'b0);

        // request and boundary in the same cycle while pending
        step();
        next_mode = 1'b1;
        new_frame = 1'b1;
        tick();
        next_mode = 1'b0;
        new_frame = 1'b0;
        chk_all("same_cycle", 2'd2, 1'b1, 1'b0, 1'b1);
        frame();
        frame();

        // camera loss does not change an active camera mode
        camera_ready = 1'b0;
        repeat (3) frame();
        chk_all("cam_loss", 2'd2, 1'b0, 1'b0, 1'b0);
        camera_ready = 1'b1;

        // reset while pending discards the request
        do_reset();
        step();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all("rst_pend", 2'd0, 1'b0, 1'b0, 1'b0);
        frame();
        chk_all("rst_pend_frame", 2'd0, 1'b0, 1'b0, 1'b0);

`ifdef VIDEO_MODE_AUTO_CYCLE_EN
        // automatic cycling: 3 steady frames, switch at the next, 2 settle frames
        do_reset();
        auto_en = 1'b1;
        for (int s = 1; s <= 4; s++) begin
            repeat (4) frame();
            chk("auto_step", {2'b00, bg}, 4'(s % 4));
            frame();
            frame();
        end
        frame();
        step();
        chk("auto_manual_pend", {3'b000, pending}, 4'd1);
        frame();
        chk("auto_manual_sw", {2'b00, bg}, 4'd1);
        frame();
        frame();
        repeat (3) frame();
        chk("auto_restart_wait", {2'b00, bg}, 4'd1);
        frame();
        chk("auto_restart_sw", {2'b00, bg}, 4'd2);
        auto_en = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/video_mode_ctrl.md
Name: video_mode_ctrl

Overview:
- Sequences the display-source select that feeds the video output mux: staff (0), camera (1), camera alt (2), camera with crosshair/mask (3).
- Takes user requests (step or direct select) and applies them only at frame boundaries.
- Blanks output for a settle window after each switch.
- Blocks camera modes until the camera pipeline reports ready.

Parameters:
- NUM_MODES, 4, number of selectable modes; next-step wraps from NUM_MODES-1 to 0; legal range 2..4.
- SETTLE_FRAMES, 2, frames blank_out stays high after a switch; legal range 1..15.
- AUTO_FRAMES, 600, frames between automatic steps (only with the optional feature).

Ports:
- clk_in  input  1  system/pixel clock
- rst_in  input  1  synchronous, active-high reset
- next_mode_in  input  1  one-cycle pulse: step to (target+1) mod NUM_MODES
- direct_mode_in  input  2  requested mode for direct select
- direct_val_in  input  1  one-cycle pulse qualifying direct_mode_in
- new_frame_in  input  1  one-cycle pulse at start of each frame
- camera_ready_in  input  1  camera pipeline locked; level signal
- auto_in  input  1  enable automatic cycling (ignored without the optional feature)
- bg_out  output  2  mode select to the video mux
- blank_out  output  1  force black/invalid output while settling
- pending_out  output  1  a request is waiting for a frame boundary
- mode_changed_out  output  1  one-cycle pulse on the cycle bg_out updates

Behaviour:
- Clock and reset: one clock, clk_in. Reset is synchronous and active-high on rst_in.
- Reset values:
  - bg_out=0, blank_out=0, pending_out=0, mode_changed_out=0.
  - target=0, state=STEADY, settle counter=0, auto counter=0.
  - Reset asserted mid-PENDING or mid-SETTLE discards the request; the block returns to mode 0 unblanked on the next cycle.
- Request capture (every cycle, all states):
  - direct_val_in has priority over next_mode_in when both are high in the same cycle.
  - direct_mode_in >= NUM_MODES is ignored.
  - next_mode_in steps from the latest target, not from bg_out, so two steps before a frame boundary advance by 2.
  - In STEADY, a request whose resulting target equals bg_out is dropped: no pending, no pulse.
- States:
  - STEADY:
    - blank_out=0, pending_out=0.
    - A valid request loads target and moves to PENDING on the next cycle.
  - PENDING:
    - pending_out=1. Further requests overwrite target.
    - On new_frame_in:
      - If target is a camera mode (1..3) and camera_ready_in=0: stay in PENDING.
      - If target==bg_out, which can happen after overwrite: go to STEADY with no pulse.
      - Otherwise: bg_out<=target, mode_changed_out=1 for that one cycle, blank_out<=1, settle counter<=SETTLE_FRAMES, go to SETTLE.
    - A request and new_frame_in in the same cycle: the new request is applied at the same boundary (the capture mux feeds the switch logic).
  - SETTLE:
    - blank_out=1.
    - Each new_frame_in decrements the settle counter; at 0 the state returns to STEADY.
    - blank_out falls on the cycle after the boundary pulse that decrements the counter to 0.
    - Requests during SETTLE are latched into target and pending_out goes to 1. On exit the state goes to PENDING instead of STEADY, so the switch happens no earlier than the next frame.
- Camera loss: camera_ready_in falling while bg_out is 1..3 does not change mode. Only requests are gated.
- Latency:
  - A request reaches bg_out at the first qualifying new_frame_in strictly after the capture cycle, or the same cycle per the simultaneous rule above.
  - bg_out is registered, giving a 1-cycle delay from the new_frame_in edge.
- Counters: the settle counter is 4 bits and the auto counter is clog2(AUTO_FRAMES+1) bits. Neither wraps; both saturate at 0.

Optional Feature:
- Macro: VIDEO_MODE_AUTO_CYCLE_EN.
- When defined:
  - While auto_in=1 and the state is STEADY, count new_frame_in pulses.
  - When the count reaches AUTO_FRAMES, issue an internal next-step request (same path as next_mode_in) and clear the count.
  - Any manual request, auto_in=0, or reset clears the count.
  - Camera gating still applies.
- When undefined: auto_in is unused, no auto counter is synthesized, and behaviour is otherwise identical.

Test Plan:
- Reset, then next_mode_in pulse with camera_ready_in=1, then new_frame_in 10 cycles later:
  - pending_out=1 from cycle+1.
  - bg_out=1 and mode_changed_out pulse 1 cycle after new_frame_in.
  - blank_out=1 for exactly 2 frames, then 0.
- Three next_mode_in pulses before one new_frame_in, starting from mode 0: bg_out goes directly to 3 with a single mode_changed_out pulse. A fourth step from 3 then wraps to 0.
- direct_val_in with direct_mode_in=2 and next_mode_in in the same cycle: target=2 and bg_out=2 after the boundary. direct_mode_in=2 while bg_out=2 in STEADY: no pending, no pulse.
- camera_ready_in=0, request mode 1, 5 new_frame_in pulses: bg_out stays 0 and pending_out stays 1. Raise ready: switch occurs at the next frame.
- Request mode 3 during SETTLE of a 0→1 switch: pending_out=1, bg_out stays 1 until SETTLE ends, then changes to 3 at the following new_frame_in. Assert rst_in mid-sequence: bg_out=0, blank_out=0, pending_out=0 the next cycle.
- With VIDEO_MODE_AUTO_CYCLE_EN, AUTO_FRAMES=3, auto_in=1: bg_out steps 0→1→2→3→0, with each step after 3 steady frames plus the settle frames. A manual next_mode_in mid-count restarts the 3-frame count.
